// File: rtl/datapath_core.sv
// Purpose: single-bus CPU datapath with 16 GPRs, HI/LO, PC, IR, MAR, Y, MDR, In_Port, C, 64-bit Z and an ALU.
// Latency: a source driven on the bus in cycle N is captured by its destination at the end of cycle N; ALU result lands in Z in the op cycle.
// Backpressure: none; every load enable is honoured on the next rising clock edge.
module datapath_core (
    input  logic        clock,
    input  logic        clear,
    input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
    input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
    input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
    input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
    input  logic        HIin,
    input  logic        LOin,
    input  logic        PCin,
    input  logic        IRin,
    input  logic        MARin,
    input  logic        Yin,
    input  logic        MDRin,
    input  logic        In_Portin,
    input  logic        Coutin,
    input  logic        Zin,
    input  logic        Zhighin,
    input  logic        Zlowin,
    input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
    input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
    input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
    input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
    input  logic        HIout,
    input  logic        LOout,
    input  logic        Zhighout,
    input  logic        Zlowout,
    input  logic        PCout,
    input  logic        MDRout,
    input  logic        In_Portout,
    input  logic        Coutout,
    input  logic        Read,
    input  logic        IncPC,
    input  logic [31:0] Mdatain,
    input  logic [4:0]  ALU_Control,
    output logic [31:0] Out_Portout
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_AND  = 5'b00010;
    localparam logic [4:0] OP_OR   = 5'b00011;
    localparam logic [4:0] OP_SHR  = 5'b00100;
    localparam logic [4:0] OP_SHRA = 5'b00101;
    localparam logic [4:0] OP_SHL  = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_MUL  = 5'b01001;
    localparam logic [4:0] OP_DIV  = 5'b01010;
    localparam logic [4:0] OP_NEG  = 5'b01011;
    localparam logic [4:0] OP_NOT  = 5'b01100;

    logic [15:0] r_in;
    logic [15:0] r_out;
    logic [31:0] r [16];
    logic [31:0] hi, lo, pc, ir, mar, y, mdr, in_port, c;
    logic [63:0] z;
    logic [31:0] bus;
    logic [63:0] alu_res;
    logic [63:0] rot_r, rot_l;
    logic signed [63:0] prod;
    logic signed [31:0] quot, rem;
    logic [4:0]  sh;

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};
    assign Out_Portout = bus;

    // Bus mux: lowest-numbered GPR wins, then the fixed source order; idle bus reads zero.
    always_comb begin
        bus = 32'h0;
        if (|r_out) begin
            for (int i = 15; i >= 0; i--) begin
                if (r_out[i]) bus = r[i];
            end
        end
        else if (HIout)      bus = hi;
        else if (LOout)      bus = lo;
        else if (Zhighout)   bus = z[63:32];
        else if (Zlowout)    bus = z[31:0];
        else if (PCout)      bus = pc;
        else if (MDRout)     bus = mdr;
        else if (In_Portout) bus = in_port;
        else if (Coutout)    bus = c;
    end

    // ALU: A is Y, B is the bus; IncPC bypasses the opcode to produce bus+1.
    always_comb begin
        sh    = bus[4:0];
        rot_r = {y, y} >> sh;
        rot_l = {y, y} << sh;
        prod  = $signed({{32{y[31]}}, y}) * $signed({{32{bus[31]}}, bus});
        quot  = 32'sh0;
        rem   = 32'sh0;
        if (bus != 32'h0) begin
            quot = $signed(y) / $signed(bus);
            rem  = $signed(y) % $signed(bus);
        end
        alu_res = 64'h0;
        if (IncPC) begin
            alu_res = {32'h0, bus + 32'd1};
        end
        else begin
            case (ALU_Control)
                OP_ADD:  alu_res = {32'h0, y + bus};
                OP_SUB:  alu_res = {32'h0, y - bus};
                OP_AND:  alu_res = {32'h0, y & bus};
                OP_OR:   alu_res = {32'h0, y | bus};
                OP_SHR:  alu_res = {32'h0, y >> sh};
                OP_SHRA: alu_res = {32'h0, $signed(y) >>> sh};
                OP_SHL:  alu_res = {32'h0, y << sh};
                OP_ROR:  alu_res = {32'h0, rot_r[31:0]};
                OP_ROL:  alu_res = {32'h0, rot_l[63:32]};
                OP_MUL:  alu_res = prod;
                OP_DIV:  alu_res = (bus == 32'h0) ? 64'h0 : {rem, quot};
                OP_NEG:  alu_res = {32'h0, 32'h0 - bus};
                OP_NOT:  alu_res = {32'h0, ~bus};
                default: alu_res = 64'h0;
            endcase
        end
    end

    // General-purpose register file; R0 behaves like any other register.
    always_ff @(posedge clock) begin
        for (int i = 0; i < 16; i++) begin
            if (!clear)      r[i] <= 32'h0;
            else if (r_in[i]) r[i] <= bus;
        end
    end

    // Special-purpose registers; clear overrides every load enable.
    always_ff @(posedge clock) begin
        if (!clear) begin
            hi <= '0; lo <= '0; pc <= '0; ir <= '0; mar <= '0;
            y <= '0; mdr <= '0; in_port <= '0; c <= '0; z <= '0;
        end
        else begin
            if (HIin)      hi      <= bus;
            if (LOin)      lo      <= bus;
            if (PCin)      pc      <= bus;
            if (IRin)      ir      <= bus;
            if (MARin)     mar     <= bus;
            if (Yin)       y       <= bus;
            if (In_Portin) in_port <= bus;
            if (MDRin)     mdr     <= Read ? Mdatain : bus;
            if (Coutin)    c       <= {{13{ir[18]}}, ir[18:0]};
            if (Zin) begin
                z <= alu_res;
            end
            else begin
                if (Zhighin) z[63:32] <= bus;
                if (Zlowin)  z[31:0]  <= bus;
            end
        end
    end

endmodule

// File: tb/tb_datapath_core.sv
module tb_datapath_core;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] r_in, r_out;
    logic        HIin, LOin, PCin, IRin, MARin, Yin, MDRin, In_Portin, Coutin;
    logic        Zin, Zhighin, Zlowin;
    logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout;
    logic        Read, IncPC;
    logic [31:0] Mdatain;
    logic [4:0]  ALU_Control;
    logic [31:0] Out_Portout;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    datapath_core dut (
        .clock(clock), .clear(clear),
        .R0in(r_in[0]),   .R1in(r_in[1]),   .R2in(r_in[2]),   .R3in(r_in[3]),
        .R4in(r_in[4]),   .R5in(r_in[5]),   .R6in(r_in[6]),   .R7in(r_in[7]),
        .R8in(r_in[8]),   .R9in(r_in[9]),   .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .HIin(HIin), .LOin(LOin), .PCin(PCin), .IRin(IRin), .MARin(MARin),
        .Yin(Yin), .MDRin(MDRin), .In_Portin(In_Portin), .Coutin(Coutin),
        .Zin(Zin), .Zhighin(Zhighin), .Zlowin(Zlowin),
        .R0out(r_out[0]),   .R1out(r_out[1]),   .R2out(r_out[2]),   .R3out(r_out[3]),
        .R4out(r_out[4]),   .R5out(r_out[5]),   .R6out(r_out[6]),   .R7out(r_out[7]),
        .R8out(r_out[8]),   .R9out(r_out[9]),   .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .HIout(HIout), .LOout(LOout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .PCout(PCout), .MDRout(MDRout), .In_Portout(In_Portout), .Coutout(Coutout),
        .Read(Read), .IncPC(IncPC), .Mdatain(Mdatain), .ALU_Control(ALU_Control),
        .Out_Portout(Out_Portout)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drop every control back to its inactive value (clear stays deasserted).
    task automatic idle();
        clear = 1'b1; r_in = '0; r_out = '0;
        HIin = 0; LOin = 0; PCin = 0; IRin = 0; MARin = 0; Yin = 0; MDRin = 0;
        In_Portin = 0; Coutin = 0; Zin = 0; Zhighin = 0; Zlowin = 0;
        HIout = 0; LOout = 0; Zhighout = 0; Zlowout = 0; PCout = 0; MDRout = 0;
        In_Portout = 0; Coutout = 0; Read = 0; IncPC = 0; Mdatain = '0; ALU_Control = '0;
    endtask

    // Advance one rising edge; inputs change 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        idle(); Mdatain = v; Read = 1; MDRin = 1; tick();
    endtask

    task automatic put_gpr(input int idx, input logic [31:0] v);
        load_mdr(v);
        idle(); MDRout = 1; r_in[idx] = 1; tick();
    endtask

    task automatic read_gpr(input string tag, input int idx, input logic [31:0] exp);
        idle(); r_out[idx] = 1; #1;
        chk(tag, {32'h0, Out_Portout}, {32'h0, exp});
        idle();
    endtask

    task automatic read_z(input string tag, input logic [63:0] exp);
        logic [31:0] hi_w, lo_w;
        idle(); Zhighout = 1; #1; hi_w = Out_Portout;
        idle(); Zlowout = 1;  #1; lo_w = Out_Portout;
        idle();
        chk(tag, {hi_w, lo_w}, exp);
    endtask

    // Y <- a, then bus <- b with the given opcode captured into Z.
    task automatic alu_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
        load_mdr(a);
        idle(); MDRout = 1; Yin = 1; tick();
        load_mdr(b);
        idle(); MDRout = 1; ALU_Control = op; Zin = 1; tick();
        idle();
    endtask

    initial begin
        idle();
        // Reset while loads are requested: the loads must be discarded.
        clear = 0; Mdatain = 32'hDEAD_BEEF; Read = 1; MDRin = 1; r_in = 16'hFFFF;
        tick();
        idle();
        #1;
        chk("idle_bus", {32'h0, Out_Portout}, 64'h0);
        for (int i = 0; i < 16; i++) read_gpr($sformatf("rst_r%0d", i), i, 32'h0);
        idle(); MDRout = 1; #1; chk("rst_mdr", {32'h0, Out_Portout}, 64'h0);
        idle(); HIout = 1;  #1; chk("rst_hi",  {32'h0, Out_Portout}, 64'h0);
        idle(); LOout = 1;  #1; chk("rst_lo",  {32'h0, Out_Portout}, 64'h0);
        idle(); PCout = 1;  #1; chk("rst_pc",  {32'h0, Out_Portout}, 64'h0);
        idle(); Coutout = 1; #1; chk("rst_c",  {32'h0, Out_Portout}, 64'h0);
        idle(); In_Portout = 1; #1; chk("rst_inport", {32'h0, Out_Portout}, 64'h0);
        read_z("rst_z", 64'h0);

        // ROL sequence: R0=0x34, R4=0x45, Y<-R0, ROL by R4[4:0]=5 -> 0x680 into R7.
        load_mdr(32'h34);
        idle(); MDRout = 1; r_in[0] = 1; #1;
        chk("mdr_on_bus", {32'h0, Out_Portout}, 64'h34);
        tick();
        put_gpr(4, 32'h45);
        idle(); r_out[0] = 1; Yin = 1; tick();
        idle(); r_out[4] = 1; ALU_Control = 5'b01000; Zin = 1; tick();
        idle(); Zlowout = 1; r_in[7] = 1; tick();
        read_gpr("rol_r7", 7, 32'h0000_0680);
        read_z("rol_zhigh_zero", 64'h0000_0000_0000_0680);

        // IncPC overrides the opcode; MAR gets the old PC, PC steps to 1.
        idle(); PCout = 1; MARin = 1; IncPC = 1; ALU_Control = 5'b00001; Zin = 1; tick();
        idle(); Zlowout = 1; PCin = 1; tick();
        chk("mar_pc0", {32'h0, dut.mar}, 64'h0);
        idle(); PCout = 1; #1; chk("pc_inc", {32'h0, Out_Portout}, 64'h1);

        // Instruction fetch into IR, then C from sign-extended IR[18:0].
        load_mdr(32'h112B_0000);
        idle(); MDRout = 1; IRin = 1; #1;
        chk("ir_bus", {32'h0, Out_Portout}, 64'h112B_0000);
        tick();
        chk("ir_val", {32'h0, dut.ir}, 64'h112B_0000);
        idle(); Coutin = 1; tick();
        idle(); Coutout = 1; #1; chk("c_pos", {32'h0, Out_Portout}, 64'h0003_0000);
        load_mdr(32'h0004_0005);
        idle(); MDRout = 1; IRin = 1; tick();
        idle(); Coutin = 1; tick();
        idle(); Coutout = 1; #1; chk("c_neg", {32'h0, Out_Portout}, 64'hFFFC_0005);

        // Multiply / divide.
        alu_op(32'hFFFF_FFFE, 32'h3, 5'b01001);  read_z("mul", 64'hFFFF_FFFF_FFFF_FFFA);
        alu_op(32'h7, 32'hFFFF_FFFE, 5'b01010);  read_z("div", 64'h0000_0001_FFFF_FFFD);
        alu_op(32'h7, 32'h0, 5'b01010);          read_z("div0", 64'h0);

        // Shifts and rotates of 0x80000000 by 4.
        alu_op(32'h8000_0000, 32'h4, 5'b00101);  read_z("shra", 64'hF800_0000);
        alu_op(32'h8000_0000, 32'h4, 5'b00100);  read_z("shr",  64'h0800_0000);
        alu_op(32'h8000_0000, 32'h4, 5'b00111);  read_z("ror",  64'h0800_0000);
        alu_op(32'h8000_0001, 32'h4, 5'b00110);  read_z("shl",  64'h10);

        // Arithmetic / logic and unused opcode.
        alu_op(32'hFFFF_FFFF, 32'h2, 5'b00000);  read_z("add_wrap", 64'h1);
        alu_op(32'h3, 32'h5, 5'b00001);          read_z("sub_wrap", 64'hFFFF_FFFE);
        alu_op(32'hF0F0_00FF, 32'h0FF0_0F0F, 5'b00010); read_z("and", 64'h00F0_000F);
        alu_op(32'hF0F0_00FF, 32'h0FF0_0F0F, 5'b00011); read_z("or",  64'hFFF0_0FFF);
        alu_op(32'h0, 32'h5, 5'b01011);          read_z("neg", 64'hFFFF_FFFB);
        alu_op(32'h0, 32'h5, 5'b01100);          read_z("not", 64'hFFFF_FFFA);
        alu_op(32'h9, 32'h5, 5'b11111);          read_z("bad_op", 64'h0);

        // Zhigh/Zlow loads from the bus, and Zin winning over both.
        load_mdr(32'hAAAA_5555);
        idle(); MDRout = 1; Zhighin = 1; Zlowin = 1; tick();
        read_z("z_halves", 64'hAAAA_5555_AAAA_5555);
        load_mdr(32'h2);
        idle(); MDRout = 1; Yin = 1; tick();
        idle(); MDRout = 1; ALU_Control = 5'b00000; Zin = 1; Zhighin = 1; Zlowin = 1; tick();
        read_z("zin_wins", 64'h4);

        // Bus priority: R3 beats HI when both drive.
        put_gpr(3, 32'h33);
        load_mdr(32'h77);
        idle(); MDRout = 1; HIin = 1; tick();
        idle(); r_out[3] = 1; HIout = 1; #1; chk("prio_r3_hi", {32'h0, Out_Portout}, 64'h33);
        idle(); HIout = 1; Coutout = 1; #1; chk("prio_hi_c", {32'h0, Out_Portout}, 64'h77);

        // Mid-operation reset clears state and discards the load.
        idle(); clear = 0; r_out[3] = 1; r_in[5] = 1; tick();
        read_gpr("rst_mid_r3", 3, 32'h0);
        read_gpr("rst_mid_r5", 5, 32'h0);
        read_z("rst_mid_z", 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath_core.md
DATAPATH_CORE -- requirements
Module: datapath

Interface
REQ-001 clock  in  1  single clock; all storage updates on rising edge.
REQ-002 clear  in  1  reset, synchronous, active-low.
REQ-003 R0in..R15in, HIin, LOin, PCin, IRin, MARin, Yin, MDRin, In_Portin, Coutin  in  1 each  load enable of the named register.
REQ-004 Zin, Zhighin, Zlowin  in  1 each  Z load enables: full ALU result, Z[63:32] from bus, Z[31:0] from bus.
REQ-005 R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout  in  1 each  bus-drive select of the named source.
REQ-006 Read  in  1  MDR input select: 1 = Mdatain, 0 = bus.
REQ-007 IncPC  in  1  forces ALU result to bus+1.
REQ-008 Mdatain  in  32  memory read data.
REQ-009 ALU_Control  in  5  ALU operation code.
REQ-010 Out_Portout  out  32  combinational copy of the current bus value.

Function
REQ-011 Storage: R0-R15, HI, LO, PC, IR, MAR, Y, MDR, In_Port, C = 32-bit; Z = 64-bit (Zhigh = Z[63:32], Zlow = Z[31:0]).
REQ-012 Each register loads on rising clock edge when its enable is high, otherwise holds; R0 is an ordinary register.
REQ-013 Registers other than MDR, Z and C load from the bus.
REQ-014 MDR loads Mdatain when Read=1, else bus.
REQ-015 C loads sign-extended IR[18:0] when Coutin=1.
REQ-016 Bus combinational; exactly one out-select expected; multiple asserted -> priority R0out..R15out, HIout, LOout, Zhighout, Zlowout, PCout, MDRout, In_Portout, Coutout (first wins); none -> bus = 0.
REQ-017 ALU combinational: A = Y, B = bus; 64-bit result; 32-bit ops zero the high half.
REQ-018 Codes: 00000 ADD A+B; 00001 SUB A-B; 00010 AND; 00011 OR; 00100 SHR logical A>>B[4:0]; 00101 SHRA arithmetic; 00110 SHL; 00111 ROR A by B[4:0]; 01000 ROL A by B[4:0]; 01001 MUL signed A*B full 64-bit; 01010 DIV signed, low = quotient, high = remainder; 01011 NEG = -B; 01100 NOT = ~B; other codes -> result 0.
REQ-019 DIV with B=0: result 64'h0.
REQ-020 IncPC=1 overrides ALU_Control: result = {32'h0, bus+1}.
REQ-021 Zin loads full 64-bit ALU result into Z; if Zin and Zhighin/Zlowin both set, Zin wins.
REQ-022 Add/sub wrap modulo 2^32; no flags.
REQ-023 Latency: source-out in cycle N -> destination updated at end of cycle N; ALU op needs Y loaded in earlier cycle, Z captured in op cycle, Z readable next cycle.

Reset
REQ-024 clear=0 at rising edge: every register including Z, C, MDR, IR, PC = 0; overrides all load enables.
REQ-025 Reset mid-operation discards in-flight loads; Out_Portout = 0 while no source is driven.

Verification
REQ-026 clear=0 one edge, then clear=1, no selects -> all registers 0, Out_Portout = 0.
REQ-027 Mdatain=0x34, Read+MDRin; then MDRout+R0in; repeat 0x45 into R4; R0out+Yin; R4out, ALU_Control=01000, Zin; Zlowout+R7in -> R7 = 0x00000680.
REQ-028 PC=0: PCout+MARin+IncPC+Zin; then Zlowout+PCin -> MAR = 0, PC = 1.
REQ-029 Mdatain=0x112B0000 with Read+MDRin, then MDRout+IRin -> IR = 0x112B0000, Out_Portout = 0x112B0000 during the MDRout cycle.
REQ-030 Y=0xFFFFFFFE, bus=3, MUL, Zin -> Z = 64'hFFFFFFFF_FFFFFFFA; DIV Y=7, bus=-2 -> Zlow = 0xFFFFFFFD, Zhigh = 1; DIV by 0 -> Z = 0.
REQ-031 Y=0x80000000, bus=4: SHRA -> 0xF8000000, SHR -> 0x08000000, ROR -> 0x08000000.
